// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl_if
// Description : Request/response bundle for serial_add_ctrl: start/operands
//               in, busy/done/result out. The sub signal and its modport
//               entries exist only when SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef SUB_EN
    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`endif
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder: one full-adder cell walks the operands LSB
//               first under a start/busy/done handshake. Define SUB_EN to add
//               the sub port (a - b via ~b and carry-in 1).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    serial_add_ctrl_if.slave  bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_ps;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sub;
    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_c;

`ifdef SUB_EN
    assign w_sub = bus.sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_last_bit);

    // The single shared full-adder cell
    assign w_s = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_ps   <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b ^ {WIDTH{w_sub}};
            r_c   <= w_sub | bus.cin;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_ps  <= {w_s, r_ps[WIDTH-1:1]};
            r_c   <= w_c;
            r_cnt <= r_cnt + CW'(1);
            // On the MSB step r_c is the carry into the MSB, so the visible
            // results are committed here and are stable for the whole DONE cycle.
            if (w_last) begin
                r_sum  <= {w_s, r_ps[WIDTH-1:1]};
                r_cout <= w_c;
                r_ovf  <= r_c ^ w_c;
            end
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire
